// File: rtl/linear_insertion_sorter.sv
// Streaming insertion sorter: keys are inserted in ascending order into a
// register array one per cycle during FILL, then drained smallest-first
// through a valid/ready output during DRAIN. Equal keys keep arrival order.
module linear_insertion_sorter #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] le;

  // Flag every occupied slot whose key is <= the incoming key; because the
  // array is ascending these flags form a run of ones from slot 0, and the
  // length of that run is the insert position (equal keys land after).
  always_comb begin
    le = '0;
    for (int i = 0; i < DEPTH; i++) begin
      le[i] = (CW'(i) < count_q) && (entry_q[i] <= in_data);
    end
  end

  // Next-state logic: shift-up insertion while filling, shift-down pop while draining.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end

    case (state_q)
      FILL: begin
        if (in_valid) begin
          entry_d[0] = le[0] ? entry_q[0] : in_data;
          for (int i = 1; i < DEPTH; i++) begin
            if (le[i]) begin
              entry_d[i] = entry_q[i];
            end else if (le[i-1]) begin
              entry_d[i] = in_data;
            end else begin
              entry_d[i] = entry_q[i-1];
            end
          end
          count_d = count_q + CW'(1);
          if (in_last || (count_q == CW'(DEPTH-1))) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          for (int i = 0; i < DEPTH-1; i++) begin
            entry_d[i] = entry_q[i+1];
          end
          entry_d[DEPTH-1] = '0;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = FILL;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State, count and key array registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = entry_q[0];
  assign out_last  = (state_q == DRAIN) && (count_q == CW'(1));
  assign count     = count_q;

endmodule

// File: tb/tb_linear_insertion_sorter.sv
// Self-checking bench for linear_insertion_sorter: a behavioural model holds
// the stored keys as a sorted queue and every DUT output is compared to it.
module tb_linear_insertion_sorter;

  localparam int WIDTH = 11;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic [CW-1:0]    count;

  int testCount = 0;
  int failCount = 0;

  // Reference model state.
  logic [WIDTH-1:0] stored[$];
  bit               mFill = 1'b1;
  int               mCount = 0;

  // Stimulus tables for applyStimulus.
  logic [WIDTH-1:0] kq[$];
  bit               lq[$];
  bit               rq[$];

  linear_insertion_sorter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .count     (count)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    stored.delete();
    mFill  = 1'b1;
    mCount = 0;
  endtask

  // One cycle: drive inputs at the falling edge, check outputs, advance the model.
  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit rdy,
                      output bit acc);
    int pos;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = rdy;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, mFill});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, !mFill});
    checkOutput("count", {28'd0, count}, mCount);
    if (!mFill) begin
      checkOutput("out_data", {21'd0, out_data}, {21'd0, stored[0]});
      checkOutput("out_last", {31'd0, out_last}, {31'd0, (stored.size() == 1)});
    end else begin
      checkOutput("out_last_fill", {31'd0, out_last}, 32'd0);
    end
    acc = 1'b0;
    if (mFill && v) begin
      pos = 0;
      while (pos < stored.size() && stored[pos] <= d) pos++;
      stored.insert(pos, d);
      mCount++;
      acc = 1'b1;
      if (l || mCount == DEPTH) mFill = 1'b0;
    end else if (!mFill && rdy) begin
      void'(stored.pop_front());
      mCount--;
      if (mCount == 0) mFill = 1'b1;
    end
    @(negedge clk);
  endtask

  // Offer kq/lq in order (held until accepted), cycling out_ready through rq,
  // until every key is offered and the model is back in FILL.
  task automatic applyStimulus(input bit junkValid);
    int idx = 0;
    int cyc = 0;
    int rIdx = 0;
    bit acc;
    while ((idx < kq.size()) || !mFill) begin
      if (cyc >= 200) begin
        testCount++;
        failCount++;
        $error("[TB] FAIL timeout observed=%0d expected=<200 cycles", cyc);
        break;
      end
      if (idx < kq.size())
        step(1'b1, kq[idx], lq[idx], rq[rIdx % rq.size()], acc);
      else
        step(junkValid, 11'h7FF, 1'b1, rq[rIdx % rq.size()], acc);
      if (acc) idx++;
      rIdx++;
      cyc++;
    end
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelClear();
    checkOutput("rst_count", {28'd0, count}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
    checkOutput("rst_out_data", {21'd0, out_data}, 32'd0);
  endtask

  initial begin
    bit acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetDut();

    $display("[TB] single frame");
    kq = {11'd5, 11'd3, 11'd9, 11'd1};
    lq = {1'b0, 1'b0, 1'b0, 1'b1};
    rq = {1'b1};
    applyStimulus(1'b0);

    $display("[TB] duplicates and stability");
    kq = {11'd7, 11'd2, 11'd7, 11'd2, 11'd0};
    lq = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b0);

    $display("[TB] full frame without in_last");
    kq = {11'd2047, 11'd0, 11'd1024, 11'd1, 11'd2046, 11'd3, 11'd512, 11'd2};
    lq = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus(1'b1);

    $display("[TB] output backpressure");
    kq = {11'd40, 11'd10, 11'd30, 11'd20};
    lq = {1'b0, 1'b0, 1'b0, 1'b1};
    rq = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    applyStimulus(1'b1);

    $display("[TB] reset during FILL");
    rq = {1'b1};
    step(1'b1, 11'd10, 1'b0, 1'b0, acc);
    step(1'b1, 11'd11, 1'b0, 1'b0, acc);
    step(1'b1, 11'd12, 1'b0, 1'b0, acc);
    resetDut();
    kq = {11'd4, 11'd4};
    lq = {1'b0, 1'b1};
    applyStimulus(1'b0);

    $display("[TB] reset during DRAIN");
    step(1'b1, 11'd9, 1'b0, 1'b0, acc);
    step(1'b1, 11'd8, 1'b0, 1'b0, acc);
    step(1'b1, 11'd7, 1'b1, 1'b0, acc);
    step(1'b0, 11'd0, 1'b0, 1'b1, acc);
    resetDut();
    kq = {11'd4, 11'd4};
    lq = {1'b0, 1'b1};
    applyStimulus(1'b0);

    $display("[TB] back-to-back frames");
    kq = {11'd3, 11'd1, 11'd6, 11'd5, 11'd4};
    lq = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b0);

    step(1'b0, 11'd0, 1'b0, 1'b1, acc);
    checkOutput("idle_count", {28'd0, count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/linear_insertion_sorter.md
Name: linear_insertion_sorter

Overview:
- Streaming insertion sorter. Accepts a frame of up to DEPTH unsigned keys and emits them in ascending order.
- Keys are inserted into a register array one per cycle as they arrive. The frame is then drained smallest-first through a valid/ready output.
- Sits directly upstream of the valid-gated delay relay stage. The relay's enable is driven from out_valid & out_ready, so that the sorted keys and their aligned sideband advance together.

Parameters:
- WIDTH, 11, key width in bits (unsigned).
- DEPTH, 8, maximum keys per frame; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  key to insert.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the final key of the frame; qualified by in_valid.
- in_ready  output  1  sorter can accept a key this cycle.
- out_data  output  WIDTH  current smallest stored key.
- out_valid  output  1  out_data valid.
- out_last  output  1  out_data is the final key of the frame.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  $clog2(DEPTH+1)  number of keys currently stored.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=FILL; count=0; all entries cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0.
  - Reset mid-frame discards all stored keys, in either state.
- Storage:
  - entry[0..DEPTH-1], kept ascending; entry[0] is the smallest.
  - Entries at index >= count are don't-care internally but are driven to 0.
- State FILL:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid & in_ready. The key is inserted in the same cycle and visible in entry[] and count the next cycle.
  - Insert position p = number of stored entries with value <= in_data. Equal keys go after existing ones, so the sort is stable.
  - entry[p] <= in_data; entry[i] <= entry[i-1] for p < i <= count; count <= count+1.
  - Transition to DRAIN when the accepted key has in_last=1, or when count becomes DEPTH (implicit end of frame).
  - in_last is ignored when in_valid=0.
- State DRAIN:
  - in_ready=0; incoming keys are not accepted and upstream must hold them.
  - out_valid=1; out_data=entry[0]; out_last=(count==1).
  - Pop occurs when out_valid & out_ready: entry[i] <= entry[i+1], top slot <= 0, count <= count-1.
  - Popping with count==1 returns to FILL with count=0. in_ready=1 again the following cycle.
  - out_data is held stable while out_ready=0.
- Latency:
  - The first sorted key is valid on the cycle after the last key is accepted.
  - Drain throughput is one key per cycle when out_ready is held high.
  - A back-to-back frame can start one cycle after out_last is accepted.
- An empty frame is impossible: every in_last travels with a key.
- Comparison is unsigned over the full WIDTH. 0 and 2^WIDTH-1 must sort correctly.
- in_data, in_valid and in_last are sampled only on clk edges; no combinational path from in_* to out_*.
- out_ready has no combinational effect on out_data, out_valid or out_last. in_ready depends only on registered state.

Test Plan:
- Reset then single frame: keys 5,3,9,1 with in_last on 1 -> out 1,3,5,9; out_last only on 9; count steps 1,2,3,4 then 3,2,1,0.
- Stability/duplicates: keys 7,2,7,2,0 (last) -> out 0,2,2,7,7. Tag the low bit via distinct WIDTH patterns to confirm equal keys leave in arrival order.
- Full frame without in_last: 8 keys 2047,0,1024,1,2046,3,512,2 -> DRAIN entered after 8th key; out 0,1,2,3,512,1024,2046,2047; in_ready=0 throughout drain.
- Output backpressure: drain 4 keys with out_ready toggling 1,0,0,1,1,0,1 -> no key lost or duplicated; out_data stable while out_ready=0; in_valid asserted during DRAIN is not accepted.
- Reset mid-operation: assert rst after 3 keys in FILL, and separately after 1 pop in DRAIN -> next cycle count=0, out_valid=0, in_ready=1; a following frame 4,4 (last) outputs 4,4 only.
- Back-to-back frames: frame A {3,1 last}, frame B {6,5,4 last} offered continuously with out_ready=1 -> out 1,3 then 4,5,6. in_ready returns 1 exactly one cycle after key 3 is popped.
